// File: rtl/enemy_shot_pool_if.sv
// ---------------------------------------------------------------------------
// enemy_shot_pool_if
//
// Bundle between the enemy-shot pool and its neighbours. The master side is
// the game environment: frame timing, the collision matrix, the launching pig's
// position, the random generator and the fire/pre-game controls. The slave side
// is the pool, which returns per-slot coordinates and status to the shot
// drawers.
//
// Signals (direction as seen by the slave / pool):
//   startOfFrame  in   one-cycle pulse per frame
//   collision     in   per-slot hit; a set bit kills that slot
//   pigTLX/pigTLY in   launching pig top-left, px
//   randomValue   in   signed launch spread
//   fire          in   launch request, level-sampled
//   preGame       in   inhibits launches while high
//   topLeftX/Y    out  flattened per-slot top-left, px; slot i at [11i+10:11i]
//   active        out  slot live mask
//   shooting      out  registered OR of active
//   launched      out  one-cycle pulse when a slot is loaded
// ---------------------------------------------------------------------------
interface enemy_shot_pool_if #(
    parameter int NUM_SHOTS = 4
);
    logic                          startOfFrame;
    logic [NUM_SHOTS-1:0]          collision;
    logic [10:0]                   pigTLX;
    logic [10:0]                   pigTLY;
    logic signed [4:0]             randomValue;
    logic                          fire;
    logic                          preGame;

    logic signed [NUM_SHOTS*11-1:0] topLeftX;
    logic signed [NUM_SHOTS*11-1:0] topLeftY;
    logic [NUM_SHOTS-1:0]          active;
    logic                          shooting;
    logic                          launched;

    modport master (
        output startOfFrame, collision, pigTLX, pigTLY, randomValue, fire, preGame,
        input  topLeftX, topLeftY, active, shooting, launched
    );

    modport slave (
        input  startOfFrame, collision, pigTLX, pigTLY, randomValue, fire, preGame,
        output topLeftX, topLeftY, active, shooting, launched
    );
endinterface

// File: rtl/enemy_shot_pool.sv
// ---------------------------------------------------------------------------
// enemy_shot_pool
//
// Pool of NUM_SHOTS independent enemy projectiles. Each slot carries a
// fixed-point position and velocity, falls under gravity (with a terminal
// downward speed), is removed by a collision, the floor or the left wall, and
// either bounces off or dies at the right wall.
//
// Once per frame a sequential sweep visits every slot (integrate, then check),
// followed by a single launch opportunity that loads the lowest free slot at
// the pig's spawn point, subject to a frame-count cooldown.
//
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     enemy_shot_pool_if.slave (frame pulse, collisions, pig position,
//           random spread, fire/preGame in; coordinates and status out)
// ---------------------------------------------------------------------------
module enemy_shot_pool #(
    parameter int NUM_SHOTS       = 4,
    parameter int FRAC_BITS       = 6,
    parameter int SPAWN_DX        = 64,
    parameter int SPAWN_DY        = -32,
    parameter int X_SPREAD        = 3,
    parameter int X_BASE          = -48,
    parameter int LAUNCH_VY       = 640,
    parameter int GRAVITY         = 16,
    parameter int MAX_VY          = 1024,
    parameter int BOUNCE_RIGHT    = 1,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int OBJ_W           = 32,
    parameter int OBJ_H           = 32,
    parameter int MARGIN          = 2
) (
    input  logic              clk,
    input  logic              resetN,
    enemy_shot_pool_if.slave  bus
);

    localparam int POS_W = 12 + FRAC_BITS;
    localparam int VEL_W = 16;
    localparam int IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    // Playfield limits for the object's top-left corner, in fixed point.
    localparam pos_t LIM_L = pos_t'(MARGIN << FRAC_BITS);
    localparam pos_t LIM_R = pos_t'((639 - MARGIN - OBJ_W) << FRAC_BITS);
    localparam pos_t LIM_T = pos_t'(MARGIN << FRAC_BITS);
    localparam pos_t LIM_B = pos_t'((479 - MARGIN - OBJ_H) << FRAC_BITS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHOTS - 1);

    typedef enum logic [1:0] {
        WAIT_ST,
        INTEG_ST,
        CHECK_ST,
        LAUNCH_ST
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state;
    state_t               state_n;
    logic [IDX_W-1:0]     idx;

    pos_t                 xpos [NUM_SHOTS];
    pos_t                 ypos [NUM_SHOTS];
    vel_t                 xvel [NUM_SHOTS];
    vel_t                 yvel [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] act_r;
    logic [NUM_SHOTS-1:0] hit_latch;
    logic [CD_W-1:0]      cooldown;
    logic                 shooting_r;
    logic                 launched_r;

    // -----------------------------------------------------------------------
    // Per-sweep datapath: values for the slot currently addressed by idx,
    // plus the spawn values for a launch.
    // -----------------------------------------------------------------------
    pos_t                 cur_x;
    pos_t                 cur_y;
    vel_t                 cur_xv;
    vel_t                 cur_yv;
    logic                 cur_act;
    pos_t                 int_x;
    pos_t                 int_y;
    logic signed [VEL_W:0] yv_sum;
    vel_t                 yv_grav;

    pos_t                 spawn_x;
    pos_t                 spawn_y;
    vel_t                 spawn_xv;
    logic                 free_found;
    logic [IDX_W-1:0]     free_slot;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the block can leave it holding a value (which would
    // infer a latch).
    always_comb begin
        cur_x   = xpos[idx];
        cur_y   = ypos[idx];
        cur_xv  = xvel[idx];
        cur_yv  = yvel[idx];
        cur_act = act_r[idx];

        // Position moves with the old velocities; gravity is applied after.
        int_x   = cur_x + pos_t'(cur_xv);
        int_y   = cur_y + pos_t'(cur_yv);

        // One extra bit so the gravity add cannot wrap before the clamp.
        yv_sum  = (VEL_W + 1)'(cur_yv) + (VEL_W + 1)'(GRAVITY);
        yv_grav = (yv_sum > (VEL_W + 1)'(MAX_VY)) ? vel_t'(MAX_VY) : vel_t'(yv_sum);

        spawn_x  = (pos_t'(bus.pigTLX) + pos_t'(SPAWN_DX)) <<< FRAC_BITS;
        spawn_y  = (pos_t'(bus.pigTLY) + pos_t'(SPAWN_DY)) <<< FRAC_BITS;
        spawn_xv = vel_t'(bus.randomValue) * vel_t'(X_SPREAD) + vel_t'(X_BASE);

        // Scan from the top so the lowest free index wins.
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!act_r[i]) begin
                free_found = 1'b1;
                free_slot  = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and per-cycle actions
    // -----------------------------------------------------------------------
    logic do_integ;
    logic do_kill;
    logic do_bounce;
    logic do_clamp_top;
    logic do_launch;
    logic cool_dec;
    logic idx_clear;
    logic idx_inc;

    always_comb begin
        state_n      = state;
        do_integ     = 1'b0;
        do_kill      = 1'b0;
        do_bounce    = 1'b0;
        do_clamp_top = 1'b0;
        do_launch    = 1'b0;
        cool_dec     = 1'b0;
        idx_clear    = 1'b0;
        idx_inc      = 1'b0;

        unique case (state)
            WAIT_ST: begin
                if (bus.startOfFrame) begin
                    idx_clear = 1'b1;
                    state_n   = INTEG_ST;
                end
            end

            INTEG_ST: begin
                do_integ = cur_act;
                state_n  = CHECK_ST;
            end

            CHECK_ST: begin
                if (cur_act) begin
                    // A live collision counts here too, so a hit landing on
                    // this very cycle is not lost.
                    if (hit_latch[idx] || bus.collision[idx]) begin
                        do_kill = 1'b1;
                    end else if (cur_y >= LIM_B || cur_x <= LIM_L) begin
                        do_kill = 1'b1;
                    end else if (cur_x >= LIM_R) begin
                        if (BOUNCE_RIGHT != 0) do_bounce = 1'b1;
                        else                   do_kill   = 1'b1;
                    end else if (cur_y < LIM_T) begin
                        do_clamp_top = 1'b1;
                    end
                end
                if (idx == LAST_IDX) begin
                    state_n = LAUNCH_ST;
                end else begin
                    idx_inc = 1'b1;
                    state_n = INTEG_ST;
                end
            end

            LAUNCH_ST: begin
                // Cooldown is consumed once per sweep, so it counts frames.
                if (cooldown != '0) begin
                    cool_dec = 1'b1;
                end else if (bus.fire && !bus.preGame && free_found) begin
                    do_launch = 1'b1;
                end
                state_n = WAIT_ST;
            end

            default: state_n = WAIT_ST;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= WAIT_ST;
        else         state <= state_n;
    end

    // -----------------------------------------------------------------------
    // Slot storage, flags, cooldown and sweep index
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments throughout, so every update in this block
    // is computed from the values present before the clock edge. Later
    // assignments to the same bit deliberately override earlier ones (a kill
    // or launch clearing a freshly latched hit).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: the slot arrays are reset element by element because a
            // reset must return every slot, mid-sweep or not, to a known
            // zero state; these are flops, not a RAM.
            for (int i = 0; i < NUM_SHOTS; i++) begin
                xpos[i] <= '0;
                ypos[i] <= '0;
                xvel[i] <= '0;
                yvel[i] <= '0;
            end
            act_r      <= '0;
            hit_latch  <= '0;
            cooldown   <= '0;
            idx        <= '0;
            shooting_r <= 1'b0;
            launched_r <= 1'b0;
        end else begin
            launched_r <= 1'b0;
            shooting_r <= |act_r;

            // Hits on free slots are ignored.
            hit_latch <= hit_latch | (bus.collision & act_r);

            if (idx_clear) idx <= '0;
            if (idx_inc)   idx <= idx + 1'b1;

            if (do_integ) begin
                xpos[idx] <= int_x;
                ypos[idx] <= int_y;
                yvel[idx] <= yv_grav;
            end

            // A killed slot keeps its last position; drawers gate on active.
            if (do_kill) begin
                act_r[idx]     <= 1'b0;
                hit_latch[idx] <= 1'b0;
            end

            if (do_bounce) begin
                xpos[idx] <= LIM_R;
                xvel[idx] <= -cur_xv;
            end

            if (do_clamp_top) begin
                ypos[idx] <= LIM_T;
                yvel[idx] <= '0;
            end

            if (cool_dec) cooldown <= cooldown - 1'b1;

            if (do_launch) begin
                xpos[free_slot]      <= spawn_x;
                ypos[free_slot]      <= spawn_y;
                xvel[free_slot]      <= spawn_xv;
                yvel[free_slot]      <= vel_t'(-LAUNCH_VY);
                act_r[free_slot]     <= 1'b1;
                hit_latch[free_slot] <= 1'b0;
                cooldown             <= CD_W'(COOLDOWN_FRAMES);
                launched_r           <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: pixel coordinates are the floor of the fixed-point position
    // (arithmetic shift), truncated to 11 bits.
    // -----------------------------------------------------------------------
    logic [NUM_SHOTS*11-1:0] tlx_c;
    logic [NUM_SHOTS*11-1:0] tly_c;

    always_comb begin
        tlx_c = '0;
        tly_c = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            tlx_c[11*i +: 11] = 11'(xpos[i] >>> FRAC_BITS);
            tly_c[11*i +: 11] = 11'(ypos[i] >>> FRAC_BITS);
        end
    end

    assign bus.topLeftX = tlx_c;
    assign bus.topLeftY = tly_c;
    assign bus.active   = act_r;
    assign bus.shooting = shooting_r;
    assign bus.launched = launched_r;

endmodule

// File: tb/tb_enemy_shot_pool.sv
// ---------------------------------------------------------------------------
// tb_enemy_shot_pool
//
// Three pool instances share one set of stimulus: dut_a uses the default
// parameters; dut_b and dut_c launch with Xvel = +200 so they reach the right
// wall quickly, dut_b bouncing and dut_c killing there.
//
// Expected launches are queued before each frame and checked by a monitor on
// every `launched` pulse of dut_a (an unqueued pulse is an error). Expected
// snapshots are queued by the stimulus and compared by a second monitor.
// ---------------------------------------------------------------------------
module tb_enemy_shot_pool;

    localparam int NS = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    logic              sof;
    logic [NS-1:0]     coll;
    logic [10:0]       pig_x;
    logic [10:0]       pig_y;
    logic signed [4:0] rv;
    logic              fire;
    logic              pre_game;

    enemy_shot_pool_if #(.NUM_SHOTS(NS)) a_if ();
    enemy_shot_pool_if #(.NUM_SHOTS(NS)) b_if ();
    enemy_shot_pool_if #(.NUM_SHOTS(NS)) c_if ();

    assign a_if.startOfFrame = sof;
    assign a_if.collision    = coll;
    assign a_if.pigTLX       = pig_x;
    assign a_if.pigTLY       = pig_y;
    assign a_if.randomValue  = rv;
    assign a_if.fire         = fire;
    assign a_if.preGame      = pre_game;

    assign b_if.startOfFrame = sof;
    assign b_if.collision    = coll;
    assign b_if.pigTLX       = pig_x;
    assign b_if.pigTLY       = pig_y;
    assign b_if.randomValue  = rv;
    assign b_if.fire         = fire;
    assign b_if.preGame      = pre_game;

    assign c_if.startOfFrame = sof;
    assign c_if.collision    = coll;
    assign c_if.pigTLX       = pig_x;
    assign c_if.pigTLY       = pig_y;
    assign c_if.randomValue  = rv;
    assign c_if.fire         = fire;
    assign c_if.preGame      = pre_game;

    enemy_shot_pool #(.NUM_SHOTS(NS)) dut_a (
        .clk(clk), .resetN(resetN), .bus(a_if.slave)
    );
    enemy_shot_pool #(.NUM_SHOTS(NS), .X_BASE(200), .BOUNCE_RIGHT(1)) dut_b (
        .clk(clk), .resetN(resetN), .bus(b_if.slave)
    );
    enemy_shot_pool #(.NUM_SHOTS(NS), .X_BASE(200), .BOUNCE_RIGHT(0)) dut_c (
        .clk(clk), .resetN(resetN), .bus(c_if.slave)
    );

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        int slot;
        int x;
        int y;
        int mask;
    } launch_t;

    typedef struct {
        string name;
        int    dut;
        int    slot;
        int    x;
        int    y;
        int    mask;
        int    shoot;
        bit    zero;
    } snap_t;

    launch_t launch_q[$];
    snap_t   snap_q[$];
    event    snap_evt;
    int      total = 0;
    int      bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] coord(input logic [NS*11-1:0] v, input int s);
        return 32'(v[11*s +: 11]);
    endfunction

    // Launch monitor on dut_a.
    initial begin
        launch_t l;
        forever begin
            @(posedge clk);
            #1;
            if (resetN && a_if.launched) begin
                check("launch_pending", 32'(launch_q.size() != 0), 1);
                if (launch_q.size() != 0) begin
                    l = launch_q.pop_front();
                    check("launch_x",      coord(a_if.topLeftX, l.slot), l.x);
                    check("launch_y",      coord(a_if.topLeftY, l.slot), l.y);
                    check("launch_active", 32'(a_if.active), l.mask);
                end
            end
        end
    end

    // Snapshot monitor.
    initial begin
        snap_t           s;
        logic [NS*11-1:0] tx;
        logic [NS*11-1:0] ty;
        logic [NS-1:0]   ac;
        logic            sh;
        logic            la;
        forever begin
            @(snap_evt);
            while (snap_q.size() != 0) begin
                s = snap_q.pop_front();
                case (s.dut)
                    0: begin tx = a_if.topLeftX; ty = a_if.topLeftY; ac = a_if.active; sh = a_if.shooting; la = a_if.launched; end
                    1: begin tx = b_if.topLeftX; ty = b_if.topLeftY; ac = b_if.active; sh = b_if.shooting; la = b_if.launched; end
                    default: begin tx = c_if.topLeftX; ty = c_if.topLeftY; ac = c_if.active; sh = c_if.shooting; la = c_if.launched; end
                endcase
                if (s.zero) begin
                    check({s.name, "_x_any"},    32'(|tx), 0);
                    check({s.name, "_y_any"},    32'(|ty), 0);
                    check({s.name, "_active"},   32'(ac), 0);
                    check({s.name, "_shooting"}, 32'(sh), 0);
                    check({s.name, "_launched"}, 32'(la), 0);
                end else begin
                    check({s.name, "_x"},        coord(tx, s.slot), s.x);
                    check({s.name, "_y"},        coord(ty, s.slot), s.y);
                    check({s.name, "_active"},   32'(ac), s.mask);
                    check({s.name, "_shooting"}, 32'(sh), s.shoot);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic push_launch(input int slot, input int x, input int y, input int mask);
        launch_t l;
        l.slot = slot; l.x = x; l.y = y; l.mask = mask;
        launch_q.push_back(l);
    endtask

    task automatic snap(input string name, input int dut, input int slot,
                        input int x, input int y, input int mask, input int shoot);
        snap_t s;
        s.name = name; s.dut = dut; s.slot = slot; s.x = x; s.y = y;
        s.mask = mask; s.shoot = shoot; s.zero = 1'b0;
        snap_q.push_back(s);
        -> snap_evt;
        #1;
    endtask

    task automatic snap_zero(input string name, input int dut);
        snap_t s;
        s.name = name; s.dut = dut; s.slot = 0; s.x = 0; s.y = 0;
        s.mask = 0; s.shoot = 0; s.zero = 1'b1;
        snap_q.push_back(s);
        -> snap_evt;
        #1;
    endtask

    // One frame: pulse, then wait past the 2*NS+1 cycle sweep.
    task automatic frame();
        @(negedge clk); sof = 1'b1;
        @(negedge clk); sof = 1'b0;
        repeat (2*NS + 3) @(negedge clk);
    endtask

    task automatic collide(input logic [NS-1:0] v);
        @(negedge clk); coll = v;
        @(negedge clk); coll = '0;
    endtask

    task automatic do_reset();
        resetN = 1'b0; sof = 1'b0; coll = '0; fire = 1'b0; pre_game = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        sof = 1'b0; coll = '0; pig_x = '0; pig_y = '0; rv = '0;
        fire = 1'b0; pre_game = 1'b0;
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        snap_zero("reset_a", 0);
        resetN = 1'b1;
        @(negedge clk);

        // Right wall on dut_b (bounce) and dut_c (kill); spawn at (602,268).
        pig_x = 11'd538; pig_y = 11'd300; rv = '0;
        fire = 1'b1; pre_game = 1'b1;
        frame();
        snap("pregame_b", 1, 0, 0, 0, 0, 0);
        pre_game = 1'b0;
        push_launch(0, 602, 268, 1);
        frame();
        fire = 1'b0;
        snap("spawn_b",   1, 0, 602, 268, 1, 1);
        frame();
        snap("bounce_b",  1, 0, 605, 258, 1, 1);
        snap("kill_c",    2, 0, 605, 258, 0, 0);
        frame();
        snap("rebound_b", 1, 0, 601, 248, 1, 1);

        do_reset();
        snap_zero("reset2_a", 0);

        // Launch, motion, cooldown spacing on dut_a.
        pig_x = 11'd100; pig_y = 11'd300; rv = '0; fire = 1'b1;
        push_launch(0, 164, 268, 1);
        frame();
        snap("launch0", 0, 0, 164, 268, 1, 1);
        frame();
        snap("motion1", 0, 0, 163, 258, 1, 1);
        frame();
        snap("motion2", 0, 0, 162, 248, 1, 1);
        for (int f = 3; f <= 39; f++) begin
            if (f == 16) push_launch(1, 164, 268, 3);
            if (f == 32) push_launch(2, 164, 268, 7);
            frame();
            if (f == 16) snap("cool_slot1", 0, 1, 164, 268, 3, 1);
        end
        snap("frame39_slot0", 0, 0, 134, 63, 7, 1);

        // Collision between frames latches; kill lands in the next sweep.
        collide(4'b0001);
        frame();
        snap("hit_slot0", 0, 0, 134, 63, 6, 1);
        snap("hit_slot1", 0, 1, 146, 97, 6, 1);

        // Refill, full pool drop, immediate relaunch, floor kill.
        for (int f = 41; f <= 112; f++) begin
            if (f == 48) push_launch(0, 164, 268, 7);
            if (f == 64) push_launch(3, 164, 268, 15);
            if (f == 81) push_launch(2, 164, 268, 15);
            frame();
            if (f == 80) begin
                snap("full_drop", 0, 3, 152, 138, 15, 1);
                collide(4'b0100);
            end
            if (f == 81)  fire = 1'b0;
            if (f == 111) snap("pre_floor",  0, 1, 92, 434, 15, 1);
            if (f == 112) snap("floor_kill", 0, 1, 92, 448, 13, 1);
        end

        // Reset in the middle of a sweep.
        @(negedge clk); sof = 1'b1;
        @(negedge clk); sof = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        #1;
        snap_zero("midsweep_reset", 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        check("launch_q_drained", 32'(launch_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_shot_pool.md
# enemy_shot_pool

Multi-projectile successor to the single enemy-shot mover. Manages `NUM_SHOTS` independent enemy projectiles, each with fixed-point position and velocity, gravity, and a selectable right-wall mode (bounce or kill). Sits between the pig/enemy position source, the random generator and the collision matrix; it feeds per-shot coordinates and an active mask to the shot drawers.

## Interface
Parameters:
- `NUM_SHOTS`, 4: number of projectile slots (1..8).
- `FRAC_BITS`, 6: fixed-point fraction bits (1 px = 2^FRAC_BITS).
- `SPAWN_DX`, 64 / `SPAWN_DY`, -32: spawn offset from pig top-left, in px.
- `X_SPREAD`, 3 / `X_BASE`, -48: launch Xvel = randomValue*X_SPREAD + X_BASE (fixed-point units).
- `LAUNCH_VY`, 640: launch Yvel = -LAUNCH_VY (upward).
- `GRAVITY`, 16: added to Yvel every frame.
- `MAX_VY`, 1024: Yvel saturates at +MAX_VY.
- `BOUNCE_RIGHT`, 1: 1 = reflect at right wall, 0 = kill at right wall.
- `COOLDOWN_FRAMES`, 15: minimum frames between launches.
- `OBJ_W`, 32 / `OBJ_H`, 32 / `MARGIN`, 2: object size and frame margin, in px.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `collision` in NUM_SHOTS: per-slot hit; a set bit kills that slot.
- `pigTLX`, `pigTLY` in 11 each: launching pig top-left, in px.
- `randomValue` in 5 signed: random launch spread.
- `fire` in 1: launch request, level-sampled.
- `preGame` in 1: inhibits launches while high.
- `topLeftX`, `topLeftY` out NUM_SHOTS*11 signed: flattened per-slot top-left in px; slot i occupies bits [11i+10:11i].
- `active` out NUM_SHOTS: slot live mask.
- `shooting` out 1: OR of `active`, registered.
- `launched` out 1: one-cycle pulse when a slot is loaded.

## Operation
- Per slot state: `Xpos` and `Ypos` signed, 12+FRAC_BITS bits; `Xvel` and `Yvel` signed, 16 bits; `active`; a sticky `hitLatch`.
- `hitLatch[i]` is set by `collision[i]` only while `active[i]` is set. It clears on kill or launch.
- Limits (fixed-point):
  - L = MARGIN
  - R = 639-MARGIN-OBJ_W
  - T = MARGIN
  - B = 479-MARGIN-OBJ_H
  - each scaled by 2^FRAC_BITS.
- FSM states: `WAIT_ST`, `INTEG_ST`, `CHECK_ST`, `LAUNCH_ST`; index counter `idx`.
  - `WAIT_ST`: on `startOfFrame`, idx <= 0 and go to `INTEG_ST`.
  - `INTEG_ST` (slot idx, only if active):
    - Xpos += Xvel, Ypos += Yvel, using the old velocities.
    - Then Yvel <= min(Yvel+GRAVITY, MAX_VY).
    - Go to `CHECK_ST`.
  - `CHECK_ST` (slot idx, only if active), checked in priority order:
    - (1) `hitLatch` or live `collision[idx]`: kill.
    - (2) Ypos >= B or Xpos <= L: kill.
    - (3) Xpos >= R: if BOUNCE_RIGHT then Xpos <= R and Xvel <= -Xvel, else kill.
    - (4) Ypos < T: Ypos <= T and Yvel <= 0.
    - Then, if idx == NUM_SHOTS-1 go to `LAUNCH_ST`; else idx++ and go to `INTEG_ST`.
  - `LAUNCH_ST`:
    - If cooldown != 0, decrement it.
    - Else if `fire` && !`preGame` && any slot free: load the lowest-index free slot:
      - Xpos = (pigTLX+SPAWN_DX) << FRAC_BITS
      - Ypos = (pigTLY+SPAWN_DY) << FRAC_BITS
      - Xvel = randomValue*X_SPREAD + X_BASE
      - Yvel = -LAUNCH_VY
      - set active, pulse `launched`, cooldown <= COOLDOWN_FRAMES.
    - Go to `WAIT_ST`.
- Kill: clear `active` and `hitLatch`; the slot holds its last position. Drawers must gate on `active`.
- Output conversion: topLeftX/Y = pos >>> FRAC_BITS (arithmetic shift, floor), truncated to 11 bits.
- Fire with all slots busy is dropped; cooldown is not reloaded.

## Timing
- Reset values:
  - all positions, velocities, `active`, `hitLatch`, cooldown, `idx` = 0.
  - `shooting` = 0, `launched` = 0, FSM in `WAIT_ST`.
- Sweep length: 2*NUM_SHOTS+1 cycles after `startOfFrame`. A `startOfFrame` arriving outside `WAIT_ST` is ignored.
- A launched shot's first move is in the next frame's sweep.
- `shooting` updates one cycle after `active` changes.
- Cooldown counts sweeps (frames), not clocks.
- A collision on the same cycle as that slot's `CHECK_ST` kills the slot in that cycle.
- A collision on an inactive slot is ignored.
- Reset asserted mid-sweep returns every slot to its reset state immediately.

## Test plan
- **Launch:** pig (100,300), randomValue=0, fire=1, cooldown 0 -> slot 0 active, launched pulse, spawn coordinates (164,268).
- **Motion:** after the launch above, one frame -> slot 0 at (163,258), Yvel=-624. After a second frame -> (162,248).
- **Multi-slot and cooldown:** fire held high for 40 frames -> launches at frames 0, 16, 32 into slots 0, 1, 2. Slot 3 stays free.
- **Collision:** assert collision=4'b0001 for 1 cycle mid-frame -> slot 0 killed at the next `CHECK_ST`. Slot 1 unaffected.
- **Right wall:** Xvel=+200, Xpos just below R:
  - BOUNCE_RIGHT=1 -> Xpos clamped to R (topLeftX=605), Xvel=-200.
  - BOUNCE_RIGHT=0 -> slot killed.
- **Bottom, full, reset:**
  - Slot falling past B=445 px -> killed.
  - All slots busy with fire=1 -> no launch, cooldown unchanged.
  - resetN low mid-sweep -> all outputs 0.
